// File: rtl/video_down_scaler.sv
// video_down_scaler
//
// Feeds the downscale-path pixel FIFO. Applies a 2x2 box filter to an RGB888 stream, which
// halves the width and the height, and writes each reduced pixel into the FIFO. Video cannot
// stall, so an output that meets a full FIFO is dropped and counted.
//
// Ports:
//   clk, rst_n      pixel clock and asynchronous active-low reset
//   in_vs           frame sync; a rising edge starts a new frame
//   in_de           active-video qualifier, one pixel per cycle while high
//   in_data         {R, G, B} pixel, 8 bits per channel
//   fifo_wr_en      FIFO write strobe (suppressed while fifo_full)
//   fifo_wr_data    reduced pixel, same channel packing
//   fifo_full       FIFO full flag
//   frame_start     one-cycle pulse after each in_vs rising edge
//   overflow        sticky per frame; set when any pixel is dropped
//   drop_cnt        dropped pixels in the current frame, saturating

module video_down_scaler #(
    parameter int unsigned H_ACT         = 1280,
    parameter int unsigned LB_ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic [23:0] in_data,
    output logic        fifo_wr_en,
    output logic [23:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic        frame_start,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    // Two extra bits let x reach H_ACT without wrapping, even when H_ACT == 2^(LB_ADDR_WIDTH+1).
    localparam int unsigned XW      = LB_ADDR_WIDTH + 2;
    localparam int unsigned LbDepth = H_ACT / 2;

    logic                     vs_q, de_q;
    logic                     armed_q, armed_d;  // low after reset until the first frame sync
    logic                     y_odd_q, y_odd_d;  // only the line parity matters
    logic [XW-1:0]            x_q, x_d;
    logic [23:0]              h_reg_q, h_reg_d;
    logic [23:0]              out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     frame_start_q, frame_start_d;
    logic                     overflow_q, overflow_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;

    logic [26:0]              lb_mem [LbDepth];
    logic [26:0]              lb_rd_q;
    logic                     lb_we, lb_re;
    logic [LB_ADDR_WIDTH-1:0] lb_addr;
    logic [26:0]              hsum;
    logic                     vs_rise;

    // Four-pixel sum plus 2, divided by 4: round half up. The maximum is 1022 >> 2 = 255.
    function automatic logic [7:0] round4(input logic [8:0] a, input logic [8:0] b);
        return 8'((10'(a) + 10'(b) + 10'd2) >> 2);
    endfunction

    assign vs_rise = in_vs & ~vs_q;
    assign lb_addr = x_q[LB_ADDR_WIDTH:1];
    assign hsum    = {9'(h_reg_q[23:16]) + 9'(in_data[23:16]),
                      9'(h_reg_q[15:8])  + 9'(in_data[15:8]),
                      9'(h_reg_q[7:0])   + 9'(in_data[7:0])};

    always_comb begin
        armed_d       = armed_q;
        y_odd_d       = y_odd_q;
        x_d           = x_q;
        h_reg_d       = h_reg_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;
        lb_we         = 1'b0;
        lb_re         = 1'b0;

        if (out_valid_q && fifo_full) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        if (vs_rise) begin
            // The frame sync wins over any pixel in the same cycle; a partial pair is lost.
            armed_d       = 1'b1;
            x_d           = '0;
            y_odd_d       = 1'b0;
            h_reg_d       = '0;
            overflow_d    = 1'b0;
            drop_cnt_d    = '0;
            frame_start_d = 1'b1;
        end else if (armed_q) begin
            if (in_de) begin
                if (x_q < XW'(H_ACT)) begin
                    x_d = x_q + XW'(1);
                    if (!x_q[0]) begin
                        h_reg_d = in_data;
                        lb_re   = y_odd_q;  // read data lands on the partner's cycle
                    end else if (!y_odd_q) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_d       = {round4(lb_rd_q[26:18], hsum[26:18]),
                                       round4(lb_rd_q[17:9],  hsum[17:9]),
                                       round4(lb_rd_q[8:0],   hsum[8:0])};
                    end
                end
            end else if (de_q) begin
                x_d     = '0;
                y_odd_d = ~y_odd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            armed_q       <= 1'b0;
            y_odd_q       <= 1'b0;
            x_q           <= '0;
            h_reg_q       <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            vs_q          <= in_vs;
            de_q          <= in_de;
            armed_q       <= armed_d;
            y_odd_q       <= y_odd_d;
            x_q           <= x_d;
            h_reg_q       <= h_reg_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Single-port line buffer holding the horizontal sums of the even line; contents unreset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_mem[lb_addr] <= hsum;
        end
        if (lb_re) begin
            lb_rd_q <= lb_mem[lb_addr];
        end
    end

    assign fifo_wr_en   = out_valid_q & ~fifo_full;
    assign fifo_wr_data = out_q;
    assign frame_start  = frame_start_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: doc/video_down_scaler.md
# video_down_scaler

Upstream feeder for the downscale-path pixel FIFO. Takes a raw RGB888 video stream in the capture clock domain and applies a 2×2 box-filter decimation, halving width and height. Each reduced pixel is written into the 24-bit asynchronous downscale FIFO. The block owns the FIFO write port and reports pixels it had to drop because the FIFO was full.

## Interface
Parameters:
- H_ACT, 1280: maximum active pixels per input line; must be even; line-buffer depth is H_ACT/2.
- LB_ADDR_WIDTH, 10: line-buffer address width; 2^LB_ADDR_WIDTH ≥ H_ACT/2.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_vs  in  1  frame sync, active high; a rising edge starts a new frame.
- in_de  in  1  active-video qualifier, one pixel per cycle while high.
- in_data  in  24  pixel, {R[23:16], G[15:8], B[7:0]}.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  24  reduced pixel, same channel packing.
- fifo_full  in  1  FIFO full flag, write-clock domain.
- frame_start  out  1  one-cycle pulse per detected in_vs rising edge.
- overflow  out  1  sticky; set when any pixel is dropped in the current frame.
- drop_cnt  out  16  number of pixels dropped in the current frame, saturating.

## Operation
- Counters:
  - x counts in_de cycles within a line and clears on each in_de falling edge.
  - y increments on each in_de falling edge.
  - On an in_vs rising edge, x, y and all pending pair state clear, overflow and drop_cnt clear, and frame_start pulses.
- Pixels with x ≥ H_ACT are ignored.
- Horizontal pass, per 8-bit channel:
  - Even x: the pixel is latched into h_reg.
  - Odd x: hsum = h_reg + pixel, 9 bits per channel.
- Vertical pass, with a single-port line buffer of H_ACT/2 × 27 bits and synchronous read:
  - Even y: hsum is written at address x>>1 on the odd-x cycle.
  - Odd y: the read is issued at address x>>1 on the even-x cycle; data arrives on the odd-x cycle.
  - Odd y then computes sum = lb + hsum, 10 bits per channel, and out = (sum + 2) >> 2. This is round-half-up and needs no saturation (max 1022>>2 = 255).
- Output:
  - out is registered together with out_valid.
  - fifo_wr_en = out_valid_q & ~fifo_full.
  - fifo_wr_data = out register.
- Drop handling: a cycle with out_valid_q=1 and fifo_full=1 writes nothing. It increments drop_cnt, saturating at 0xFFFF, and sets overflow. There is no retry; video cannot stall.
- Odd line length: a trailing even-x pixel with no partner is discarded.
- Odd line count: the final unpaired even line is never emitted.
- in_vs rising mid-line or mid-pair: the partial pair is discarded and no output is produced for it. An output already in out_valid_q still completes.
- almost_full is not consumed.

## Timing
- Reset values: fifo_wr_en=0, fifo_wr_data=0, frame_start=0, overflow=0, drop_cnt=0; all counters, h_reg and out_valid_q are 0. Line-buffer contents are undefined.
- Latency: an odd-x pixel of an odd line at cycle t produces fifo_wr_en at t+1.
- Output rate:
  - At most one write every 2 cycles.
  - Writes occur only during odd lines.
  - H_ACT/2 writes per odd line.
- frame_start asserts the cycle after in_vs is sampled 0→1, for exactly one cycle.
- drop_cnt and overflow update in the cycle after the dropped strobe.
- Reset assertion mid-frame:
  - Outputs clear immediately (asynchronous).
  - After release, no output is produced until the next in_vs rising edge.
  - Pixels before that edge are ignored.

## Test plan
- Basic 2×2 averaging, H_ACT=4, fifo_full=0:
  - Stimulus: row0 = 0x000000, 0x040404, 0x101010, 0x202020; row1 = 0x010101, 0x030303, 0xFFFFFF, 0xFFFFFF.
  - Required: exactly two writes, 0x020202 then 0x8C8C8C, each one cycle after the odd pixel; no writes during row0.
- Rounding and channel independence:
  - Stimulus: 2×2 block of 0x010203 ×3 and 0x020304.
  - Required: one write of 0x010203. Channel sums are R=5→1, G=9→2, B=13→3.
- FIFO full:
  - Stimulus: fifo_full held high across the second output of a 4×2 frame.
  - Required: only the first pixel is written; drop_cnt=1, overflow=1.
  - Required: the next in_vs rising edge clears both and pulses frame_start.
- Odd width and odd height:
  - Stimulus: 5-pixel lines, 3 lines.
  - Required: 2 writes total, only on line 1; the 5th pixel and line 2 produce nothing.
- in_vs mid-pair:
  - Stimulus: raise in_vs after the even pixel of an odd line.
  - Required: no write for that pair; x=y=0 afterwards; the next frame's output is correct.
- Asynchronous reset mid-frame:
  - Stimulus: pulse rst_n low during active video.
  - Required: all outputs are 0 during reset; no fifo_wr_en until after the next in_vs rising edge.
